bcd_serial_subtractor: RTL and testbench

Digit-serial, multi-digit BCD subtractor that computes A − B − borrow-in over packed BCD operands, one decimal digit per clock. It is the inverse datapath to the team's combinational BCD adder. It is used wherever the decimal arithmetic unit needs differences, for example countdown values and balance decrements. It trades latency for a single 4-bit digit stage and exposes a start/busy/done handshake to the controlling FSM.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_sub.sv | 21 ++
 rtl/bcd_serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit validity check for the serial BCD subtractor.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract stage: d = a_d - b_d - bi, wrapped by +10 on borrow.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo,
  output logic       invalid
);
  logic signed [4:0] t;

  always_comb begin
    t       = $signed({1'b0, a_d}) - $signed({1'b0, b_d}) - $signed({4'b0000, bi});
    bo      = t[4];
    // Low nibble plus 10 modulo 16 equals the low nibble of t + 10.
    d       = t[3:0] + (bo ? 4'd10 : 4'd0);
    invalid = digit_invalid(a_d) | digit_invalid(b_d);
  end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor, A - B - bin, one digit per clock with start/busy/done handshake.
// Define BCD_SUB_SIGN_MAG_EN to add the NEG pass that returns sign-magnitude results.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// SUB   | one digit of A - B - bin per cycle, LSD first
// NEG   | 0 - result per digit to form the magnitude (sign-magnitude build only)
// DONE  | output registers load; done pulses on the following cycle
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*DIGITS-1:0]    a,
  input  logic [4*DIGITS-1:0]    b,
  input  logic                   bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*DIGITS-1:0]    diff,
  output logic                   bout,
  output logic                   neg,
  output logic                   err
);
  localparam int W = DIGIT_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0] a_sr, b_sr, r_sr, r_nxt;
  logic brw, bout_r, err_acc;
  logic load, sub_en, neg_en, last_digit;
  logic [3:0] st_a, st_b, st_d;
  logic st_bo, st_inv;

  assign last_digit = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SUB;
      SUB: begin
        if (last_digit) begin
`ifdef BCD_SUB_SIGN_MAG_EN
          state_nxt = st_bo ? NEG : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef BCD_SUB_SIGN_MAG_EN
      NEG:  if (last_digit) state_nxt = DONE;
`endif
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    load   = (state == IDLE) && start;
    sub_en = (state == SUB);
`ifdef BCD_SUB_SIGN_MAG_EN
    neg_en = (state == NEG);
`else
    neg_en = 1'b0;
`endif
  end

  // The NEG pass reuses the digit stage as 0 - result, consuming and refilling r_sr in place.
  always_comb begin
    st_a  = neg_en ? 4'd0 : a_sr[3:0];
    st_b  = neg_en ? r_sr[3:0] : b_sr[3:0];
    r_nxt = r_sr >> DIGIT_W;
    r_nxt[W-1 -: DIGIT_W] = st_d;
  end

  bcd_digit_sub u_digit (
    .a_d     (st_a),
    .b_d     (st_b),
    .bi      (brw),
    .d       (st_d),
    .bo      (st_bo),
    .invalid (st_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      brw     <= 1'b0;
      bout_r  <= 1'b0;
      err_acc <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (load) begin
        a_sr    <= a;
        b_sr    <= b;
        brw     <= bin;
        cnt     <= '0;
        err_acc <= 1'b0;
      end else if (sub_en) begin
        a_sr    <= a_sr >> DIGIT_W;
        b_sr    <= b_sr >> DIGIT_W;
        r_sr    <= r_nxt;
        err_acc <= err_acc | st_inv;
        // Final borrow is kept as bout; the NEG pass must start from a clear borrow.
        brw     <= last_digit ? 1'b0 : st_bo;
        if (last_digit) bout_r <= st_bo;
        cnt     <= last_digit ? '0 : cnt + 1'b1;
      end else if (neg_en) begin
        r_sr <= r_nxt;
        brw  <= st_bo;
        cnt  <= last_digit ? '0 : cnt + 1'b1;
      end
      if (state == DONE) begin
        diff <= r_sr;
        bout <= bout_r;
        err  <= err_acc;
      end
    end
  end

`ifdef BCD_SUB_SIGN_MAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              neg <= 1'b0;
    else if (state == DONE)  neg <= bout_r;
  end
`else
  assign neg = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4), honours BCD_SUB_SIGN_MAG_EN.
module tb_bcd_serial_subtractor;
  localparam int D = 4;
  localparam int W = 4 * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic bin = 1'b0;
  logic busy, done, bout, neg, err;
  logic [W-1:0] diff;

  int vectors = 0;
  int errors = 0;

  bcd_serial_subtractor #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Reference: plain integer arithmetic on decimal values.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo, output logic mng,
                                output int mlat);
    int x;
    x = bcd2int(ma) - bcd2int(mb) - int'(mbin);
    mbo = (x < 0);
    mng = 1'b0;
    mlat = D + 1;
    if (x >= 0) md = int2bcd(x);
    else begin
`ifdef BCD_SUB_SIGN_MAG_EN
      md = int2bcd(-x);
      mng = 1'b1;
      mlat = 2 * D + 1;
`else
      md = int2bcd(x + 10 ** D);
`endif
    end
  endfunction

  // Drives one operation; returns the outputs at done and the edge count to done (0 on timeout).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        output logic [W-1:0] gd, output logic gbo, output logic gng,
                        output logic gerr, output int lat, output logic busy1);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    lat = 0;
    for (int i = 1; i <= 3 * D + 4; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    gd = diff; gbo = bout; gng = neg; gerr = err;
  endtask

  task automatic test_reset();
    vectors++;
    if ({busy, done, diff, bout, neg, err} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b neg=%b err=%b, want all 0",
               busy, done, diff, bout, neg, err);
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input logic want_err, input logic chk_diff);
    logic [W-1:0] ed, gd;
    logic ebo, eng, gbo, gng, gerr, b1;
    int elat, glat;
    model(ta, tb, tbin, ed, ebo, eng, elat);
    run_op(ta, tb, tbin, gd, gbo, gng, gerr, glat, b1);
    vectors++;
    if (glat !== elat || b1 !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d busy1=%b, want %0d busy1=1", name, glat, b1, elat);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b, want 0", name, busy);
    end
    if (chk_diff) begin
      vectors++;
      if (gd !== ed || gbo !== ebo || gng !== eng) begin
        errors++;
        $display("FAIL %s result: got diff=%h bout=%b neg=%b, want diff=%h bout=%b neg=%b",
                 name, gd, gbo, gng, ed, ebo, eng);
      end
    end
    vectors++;
    if (gerr !== want_err) begin
      errors++;
      $display("FAIL %s err: got %b, want %b", name, gerr, want_err);
    end
  endtask

  task automatic test_directed();
    check_op("d93m45", 16'h0093, 16'h0045, 1'b0, 1'b0, 1'b1);
    check_op("ripple", 16'h1000, 16'h0001, 1'b0, 1'b0, 1'b1);
    check_op("negative", 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1);
    check_op("bin_zero", 16'h0050, 16'h0049, 1'b1, 1'b0, 1'b1);
    check_op("invalid", 16'h00A0, 16'h0000, 1'b0, 1'b1, 1'b0);
    check_op("err_clear", 16'h0012, 16'h0003, 1'b0, 1'b0, 1'b1);
    check_op("all_nines", 16'h0000, 16'h9999, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      check_op("random", rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      check_op("back_to_back", rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] ed, prev;
    logic ebo, eng;
    int elat, ndone;
    prev = diff;
    model(16'h0731, 16'h0256, 1'b0, ed, ebo, eng, elat);
    @(negedge clk);
    a = 16'h0731; b = 16'h0256; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      start = (i == 1 || i == 3);
      a = 16'h0999; b = 16'h0000;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        vectors++;
        if (diff !== ed || bout !== ebo) begin
          errors++;
          $display("FAIL ignore_start result: got diff=%h bout=%b, want diff=%h bout=%b",
                   diff, bout, ed, ebo);
        end
      end else if (ndone == 0) begin
        vectors++;
        if (diff !== prev) begin
          errors++;
          $display("FAIL ignore_start hold: got diff=%h at cycle %0d, want %h", diff, i, prev);
        end
      end
    end
    vectors++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_start done_count: got %0d, want 1", ndone);
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    @(negedge clk);
    a = 16'h0093; b = 16'h0045; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, diff, bout, neg, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: got busy=%b done=%b diff=%h bout=%b neg=%b err=%b, want all 0",
               busy, done, diff, bout, neg, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    vectors++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid no_done: got %0d busy/done cycles, want 0", ndone);
    end
    check_op("after_reset", 16'h0093, 16'h0045, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
